grf_wb_arbiter: RTL and testbench

Write-back arbiter for the single GRF write port. Shares the port between the in-order pipeline write-back (port 0) and a multi-cycle result source (port 1, e.g. multiply/divide or slow load), buffering port 1 results in a small FIFO. Port 0 has priority, and a starvation counter guarantees port 1 forward progress. A query port reports whether a register has a buffered pending write, for use by stall logic.

---
 rtl/grf_wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_grf_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: write-back arbiter for the single GRF write port.
//
// Shares the GRF write port between the in-order pipeline write-back (port 0)
// and a multi-cycle result source (port 1). Port 1 results are buffered in a
// FIFO_DEPTH-entry FIFO. Port 0 has priority. A starvation counter forces the
// FIFO head through after STARVE_MAX consecutive denied cycles. q_busy reports
// whether a register has a buffered pending write, for use by stall logic.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   p0_valid/p0_ready        pipeline write request / accepted when both high
//   p0_wa/p0_wd/p0_pc        pipeline destination register, data, PC
//   p1_valid/p1_ready        multi-cycle unit request / FIFO not full
//   p1_wa/p1_wd/p1_pc        multi-cycle unit destination register, data, PC
//   q_ra/q_busy              query register / pending buffered write (comb.)
//   grf_we/wa/wd/wpc         registered GRF write enable, address, data, PC
//
// Optional macro GRF_WB_TRACE_EN: when defined, every registered write with a
// nonzero address prints a trace line in the CPU trace format.

module grf_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [4:0]  p0_wa,
    input  logic [31:0] p0_wd,
    input  logic [31:0] p0_pc,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [4:0]  p1_wa,
    input  logic [31:0] p1_wd,
    input  logic [31:0] p1_pc,
    input  logic [4:0]  q_ra,
    output logic        q_busy,
    output logic        grf_we,
    output logic [4:0]  grf_wa,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_wpc
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [4:0]      fifo_wa [FIFO_DEPTH];
    logic [31:0]     fifo_wd [FIFO_DEPTH];
    logic [31:0]     fifo_pc [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] occ_q;
    logic [3:0]      starve_q;

    logic            fifo_nonempty;
    logic            fifo_full;
    logic            force_head;
    logic            grant_head;
    logic            grant_p0;
    logic            grant_valid;
    logic [4:0]      grant_wa;
    logic [31:0]     grant_wd;
    logic [31:0]     grant_pc;
    logic            push;

    assign fifo_nonempty = (occ_q != '0);
    assign fifo_full     = (occ_q == CntW'(FIFO_DEPTH));
    assign force_head    = (starve_q >= 4'(STARVE_MAX)) && fifo_nonempty;

    assign grant_head = fifo_nonempty && (force_head || !p0_valid);
    assign grant_p0   = p0_valid && !force_head;
    assign p0_ready   = !force_head;
    // Ready is based on pre-edge occupancy, so a same-cycle pop never frees a slot.
    assign p1_ready   = !fifo_full;
    assign push       = p1_valid && !fifo_full;

    always_comb begin
        grant_valid = 1'b0;
        grant_wa    = 5'd0;
        grant_wd    = 32'd0;
        grant_pc    = 32'd0;
        if (grant_head) begin
            grant_valid = 1'b1;
            grant_wa    = fifo_wa[rd_ptr_q];
            grant_wd    = fifo_wd[rd_ptr_q];
            grant_pc    = fifo_pc[rd_ptr_q];
        end else if (grant_p0) begin
            grant_valid = 1'b1;
            grant_wa    = p0_wa;
            grant_wd    = p0_wd;
            grant_pc    = p0_pc;
        end
    end

    // Scan only occupied slots; the head being popped still counts as pending.
    always_comb begin
        logic [PtrW-1:0] idx;
        idx    = '0;
        q_busy = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            idx = rd_ptr_q + PtrW'(i);
            if ((CntW'(i) < occ_q) && (fifo_wa[idx] == q_ra) && (q_ra != 5'd0)) begin
                q_busy = 1'b1;
            end
        end
    end

    // Storage needs no reset; validity is tracked by the occupancy count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_wa[wr_ptr_q] <= p1_wa;
            fifo_wd[wr_ptr_q] <= p1_wd;
            fifo_pc[wr_ptr_q] <= p1_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            starve_q <= 4'd0;
            grf_we   <= 1'b0;
            grf_wa   <= 5'd0;
            grf_wd   <= 32'd0;
            grf_wpc  <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (grant_head) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push, grant_head})
                2'b10:   occ_q <= occ_q + CntW'(1);
                2'b01:   occ_q <= occ_q - CntW'(1);
                default: occ_q <= occ_q;
            endcase

            if (!fifo_nonempty || grant_head) begin
                starve_q <= 4'd0;
            end else if (grant_p0) begin
                starve_q <= starve_q + 4'd1;
            end

            if (grant_valid) begin
                // A write to register 0 is consumed without enabling the GRF.
                grf_we  <= (grant_wa != 5'd0);
                grf_wa  <= grant_wa;
                grf_wd  <= grant_wd;
                grf_wpc <= grant_pc;
            end else begin
                grf_we  <= 1'b0;
            end
        end
    end

`ifdef GRF_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && grant_valid && (grant_wa != 5'd0)) begin
            $display("@%h: $%d <= %h", grant_pc, grant_wa, grant_wd);
        end
    end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: directed steps followed by random
// traffic, all checked against a queue-based reference model of the arbiter.

module tb_grf_wb_arbiter;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned STARVE_MAX = 4;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p0_ready;
    logic [4:0]  p0_wa;
    logic [31:0] p0_wd, p0_pc;
    logic        p1_valid, p1_ready;
    logic [4:0]  p1_wa;
    logic [31:0] p1_wd, p1_pc;
    logic [4:0]  q_ra;
    logic        q_busy;
    logic        grf_we;
    logic [4:0]  grf_wa;
    logic [31:0] grf_wd, grf_wpc;

    grf_wb_arbiter #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .p0_valid(p0_valid),
        .p0_ready(p0_ready),
        .p0_wa   (p0_wa),
        .p0_wd   (p0_wd),
        .p0_pc   (p0_pc),
        .p1_valid(p1_valid),
        .p1_ready(p1_ready),
        .p1_wa   (p1_wa),
        .p1_wd   (p1_wd),
        .p1_pc   (p1_pc),
        .q_ra    (q_ra),
        .q_busy  (q_busy),
        .grf_we  (grf_we),
        .grf_wa  (grf_wa),
        .grf_wd  (grf_wd),
        .grf_wpc (grf_wpc)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    entry_t      fq[$];
    int          starve;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd, m_pc;
    logic        m_data_known;

    // Last values observed mid-cycle, for directed checks
    logic obs_p0r, obs_p1r, obs_qb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check combinational outputs mid-cycle, advance the
    // model across the edge, then check the registered outputs.
    task automatic cycle();
        logic   frc, g_head, g_p0, exp_qb, pushed;
        entry_t e;
        @(negedge clk);
        frc    = (starve >= STARVE_MAX) && (fq.size() > 0);
        exp_qb = 1'b0;
        foreach (fq[i]) if (q_ra != 5'd0 && fq[i].wa == q_ra) exp_qb = 1'b1;
        obs_p0r = p0_ready;
        obs_p1r = p1_ready;
        obs_qb  = q_busy;
        chk("p0_ready", {31'd0, p0_ready}, {31'd0, !frc});
        chk("p1_ready", {31'd0, p1_ready}, {31'd0, fq.size() < FIFO_DEPTH});
        chk("q_busy", {31'd0, q_busy}, {31'd0, exp_qb});

        g_head = (fq.size() > 0) && (frc || !p0_valid);
        g_p0   = !g_head && p0_valid;
        pushed = p1_valid && (fq.size() < FIFO_DEPTH);

        if (fq.size() == 0 || g_head) starve = 0;
        else if (g_p0) starve++;

        if (g_head) begin
            e = fq.pop_front();
        end else if (g_p0) begin
            e.wa = p0_wa; e.wd = p0_wd; e.pc = p0_pc;
        end
        if (g_head || g_p0) begin
            m_we = (e.wa != 5'd0);
            m_wa = e.wa; m_wd = e.wd; m_pc = e.pc;
            m_data_known = m_we;
        end else begin
            m_we = 1'b0;
        end
        if (pushed) begin
            e.wa = p1_wa; e.wd = p1_wd; e.pc = p1_pc;
            fq.push_back(e);
        end

        @(posedge clk);
        #1;
        chk("grf_we", {31'd0, grf_we}, {31'd0, m_we});
        if (m_data_known) begin
            chk("grf_wa", {27'd0, grf_wa}, {27'd0, m_wa});
            chk("grf_wd", grf_wd, m_wd);
            chk("grf_wpc", grf_wpc, m_pc);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        fq.delete();
        starve = 0;
        m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_pc = 32'd0;
        m_data_known = 1'b1;
        chk("rst_grf_we", {31'd0, grf_we}, 32'd0);
        chk("rst_grf_wa", {27'd0, grf_wa}, 32'd0);
        chk("rst_grf_wd", grf_wd, 32'd0);
        chk("rst_grf_wpc", grf_wpc, 32'd0);
    endtask

    initial begin
        int k;
        int blocked;
        p0_wa = 5'd0; p0_wd = 32'd0; p0_pc = 32'd0;
        p1_wa = 5'd0; p1_wd = 32'd0; p1_pc = 32'd0;
        q_ra  = 5'd0;
        @(posedge clk);
        #1;
        do_reset();

        // Idle after reset
        q_ra = 5'd3;
        repeat (10) cycle();

        // Port 0 only
        p0_valid = 1'b1; p0_wa = 5'd5; p0_wd = 32'h1234; p0_pc = 32'h3000;
        cycle();
        chk("p0_we", {31'd0, grf_we}, 32'd1);
        chk("p0_wa", {27'd0, grf_wa}, 32'd5);
        chk("p0_wd", grf_wd, 32'h1234);
        chk("p0_wpc", grf_wpc, 32'h3000);
        p0_wa = 5'd0;
        cycle();
        chk("p0_r0_we", {31'd0, grf_we}, 32'd0);
        p0_valid = 1'b0;
        cycle();

        // Port 1 push into empty FIFO, no bypass
        p1_valid = 1'b1; p1_wa = 5'd8; p1_wd = 32'hAA; p1_pc = 32'h3010; q_ra = 5'd8;
        cycle();
        chk("p1_no_bypass_we", {31'd0, grf_we}, 32'd0);
        p1_valid = 1'b0;
        cycle();
        chk("p1_q_busy", {31'd0, obs_qb}, 32'd1);
        chk("p1_we", {31'd0, grf_we}, 32'd1);
        chk("p1_wa", {27'd0, grf_wa}, 32'd8);
        chk("p1_wd", grf_wd, 32'hAA);
        chk("p1_wpc", grf_wpc, 32'h3010);
        cycle();

        // Starvation: p0 held valid, one p1 entry
        do_reset();
        p0_valid = 1'b1; p0_wa = 5'd3; p0_wd = 32'h33; p0_pc = 32'h4000;
        p1_valid = 1'b1; p1_wa = 5'd9; p1_wd = 32'h99; p1_pc = 32'h4100;
        cycle();
        p1_valid = 1'b0;
        for (int i = 0; i < STARVE_MAX; i++) begin
            cycle();
            chk("starve_p0_ready", {31'd0, obs_p0r}, 32'd1);
            chk("starve_p0_wa", {27'd0, grf_wa}, 32'd3);
        end
        cycle();
        chk("starve_forced_ready", {31'd0, obs_p0r}, 32'd0);
        chk("starve_forced_wa", {27'd0, grf_wa}, 32'd9);
        cycle();
        chk("starve_resume_ready", {31'd0, obs_p0r}, 32'd1);
        chk("starve_resume_wa", {27'd0, grf_wa}, 32'd3);

        // FIFO full: three back-to-back pushes with p0 held valid
        do_reset();
        p0_valid = 1'b1; p0_wa = 5'd1; p0_wd = 32'h11; p0_pc = 32'h5000;
        k = 0;
        blocked = 0;
        p1_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            p1_valid = (k < 3);
            p1_wa = 5'(12 + k); p1_wd = 32'hB0 + 32'(k); p1_pc = 32'h5100 + 32'(4 * k);
            cycle();
            if (p1_valid && obs_p1r) k++;
            if (p1_valid && !obs_p1r) blocked++;
        end
        chk("full_all_pushed", k, 3);
        chk("full_blocked_seen", {31'd0, blocked > 0}, 32'd1);
        chk("full_drained", fq.size(), 0);

        // Reset with two entries pending
        do_reset();
        p0_valid = 1'b1; p0_wa = 5'd2;
        p1_valid = 1'b1; p1_wa = 5'd10; p1_wd = 32'hA0; p1_pc = 32'h6000;
        cycle();
        p1_wa = 5'd11; p1_wd = 32'hA1; p1_pc = 32'h6004;
        cycle();
        chk("pend_two", fq.size(), 2);
        do_reset();
        q_ra = 5'd10;
        cycle();
        chk("rst_q_busy_10", {31'd0, obs_qb}, 32'd0);
        chk("rst_p1_ready", {31'd0, obs_p1r}, 32'd1);
        q_ra = 5'd11;
        cycle();
        chk("rst_q_busy_11", {31'd0, obs_qb}, 32'd0);
        chk("rst_no_we", {31'd0, grf_we}, 32'd0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(199) == 0) do_reset();
            p0_valid = ($urandom_range(99) < 55);
            p0_wa    = 5'($urandom_range(7));
            p0_wd    = $urandom;
            p0_pc    = $urandom;
            p1_valid = ($urandom_range(99) < 40);
            p1_wa    = 5'($urandom_range(7));
            p1_wd    = $urandom;
            p1_pc    = $urandom;
            q_ra     = 5'($urandom_range(7));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
